// File: rtl/io_pkg.sv
// Shared address map, status bit positions and address decode for the IO bus controller.
package io_pkg;

  localparam logic [7:0] IO_LED     = 8'h00;
  localparam logic [7:0] IO_TX_STAT = 8'h04;
  localparam logic [7:0] IO_TX_DATA = 8'h08;
  localparam logic [7:0] IO_RX_STAT = 8'h10;
  localparam logic [7:0] IO_RX_DATA = 8'h14;
  localparam logic [7:0] IO_CYCLE   = 8'h18;
  localparam logic [7:0] IO_OVF_CLR = 8'h1C;

  localparam int TX_STAT_NOT_FULL  = 0;
  localparam int TX_STAT_OVF       = 1;
  localparam int RX_STAT_NOT_EMPTY = 0;
  localparam int RX_STAT_OVF       = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_TX_STAT,
    SEL_TX_DATA,
    SEL_RX_STAT,
    SEL_RX_DATA,
    SEL_CYCLE,
    SEL_OVF_CLR
  } io_sel_e;

  // Caller passes a word-aligned address; low two bits are already masked.
  function automatic io_sel_e io_decode(input logic [7:0] word_addr);
    io_sel_e sel;
    case (word_addr)
      IO_LED:     sel = SEL_LED;
      IO_TX_STAT: sel = SEL_TX_STAT;
      IO_TX_DATA: sel = SEL_TX_DATA;
      IO_RX_STAT: sel = SEL_RX_STAT;
      IO_RX_DATA: sel = SEL_RX_DATA;
      IO_CYCLE:   sel = SEL_CYCLE;
      IO_OVF_CLR: sel = SEL_OVF_CLR;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] status_word(input logic ovf, input logic flag);
    logic [31:0] w;
    w = '0;
    w[1] = ovf;
    w[0] = flag;
    return w;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is dropped and ovf_set pulses.
module io_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf_set
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !do_pop;

  // Empty FIFO presents zero so downstream readers never see stale data.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped peripheral controller: LED register, tx/rx FIFOs, cycle counter,
// with a zero-latency combinational read path back to the CPU.
module io_bus_ctrl
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  output logic [LED_W-1:0] led,
  output logic [31:0]      seg_data,
  output logic             seg_valid,
  input  logic             seg_ready,
  input  logic [31:0]      sw_data,
  input  logic             sw_valid
);

  logic [7:0]       word_addr;
  io_sel_e          sel;
  logic [LED_W-1:0] led_reg;
  logic [31:0]      cycle_reg;
  logic             tx_ovf_reg;
  logic             rx_ovf_reg;

  logic             tx_push;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_ovf_set;
  logic [31:0]      tx_head;

  logic             rx_pop;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_ovf_set;
  logic [31:0]      rx_head;

  logic             ovf_clr;

  assign word_addr = io_addr & 8'hFC;
  assign sel       = io_decode(word_addr);

  assign tx_push = io_we && (sel == SEL_TX_DATA);
  assign rx_pop  = io_rd && (sel == SEL_RX_DATA);
  assign ovf_clr = io_we && (sel == SEL_OVF_CLR);

  io_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .din     (io_dout),
    .pop     (seg_ready),
    .dout    (tx_head),
    .empty   (tx_empty),
    .full    (tx_full),
    .ovf_set (tx_ovf_set)
  );

  io_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (sw_valid),
    .din     (sw_data),
    .pop     (rx_pop),
    .dout    (rx_head),
    .empty   (rx_empty),
    .full    (rx_full),
    .ovf_set (rx_ovf_set)
  );

  assign seg_data  = tx_head;
  assign seg_valid = !tx_empty;
  assign led       = led_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg   <= '0;
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (io_we && (sel == SEL_LED)) begin
        led_reg <= io_dout[LED_W-1:0];
      end
    end
  end

  // A fresh overflow in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_reg <= 1'b0;
      rx_ovf_reg <= 1'b0;
    end else begin
      if (tx_ovf_set) begin
        tx_ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        tx_ovf_reg <= 1'b0;
      end
      if (rx_ovf_set) begin
        rx_ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        rx_ovf_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    io_din = '0;
    case (sel)
      SEL_LED:     io_din = 32'(led_reg);
      SEL_TX_STAT: io_din = status_word(tx_ovf_reg, !tx_full);
      SEL_RX_STAT: io_din = status_word(rx_ovf_reg, !rx_empty);
      SEL_RX_DATA: io_din = rx_head;
      SEL_CYCLE:   io_din = cycle_reg;
      default:     io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: queue models of both FIFOs plus sticky-flag model.
module tb_io_bus_ctrl;
  import io_pkg::*;

  localparam int DEPTH = 4;
  localparam int LED_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       io_addr = '0;
  logic [31:0]      io_dout = '0;
  logic             io_we = 1'b0;
  logic             io_rd = 1'b0;
  logic [31:0]      io_din;
  logic [LED_W-1:0] led;
  logic [31:0]      seg_data;
  logic             seg_valid;
  logic             seg_ready = 1'b0;
  logic [31:0]      sw_data = '0;
  logic             sw_valid = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        tx_ovf_m = 1'b0;
  logic        rx_ovf_m = 1'b0;

  io_bus_ctrl #(.FIFO_DEPTH(DEPTH), .LED_W(LED_W)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_rd(io_rd), .io_din(io_din), .led(led), .seg_data(seg_data),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .sw_data(sw_data), .sw_valid(sw_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] tx_stat_m();
    return {30'b0, tx_ovf_m, (tx_q.size() < DEPTH)};
  endfunction

  function automatic logic [31:0] rx_stat_m();
    return {30'b0, rx_ovf_m, (rx_q.size() != 0)};
  endfunction

  // Single-cycle store; the model is updated as the stimulus is driven (seg_ready low).
  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_dout = d; io_we = 1'b1;
    if (a == IO_TX_DATA) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(d); else tx_ovf_m = 1'b1;
    end
    if (a == IO_OVF_CLR) begin
      tx_ovf_m = 1'b0; rx_ovf_m = 1'b0;
    end
    @(posedge clk); #1 io_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(posedge clk); #1 io_rd = 1'b0;
  endtask

  task automatic sw_push(input logic [31:0] d);
    @(negedge clk);
    sw_data = d; sw_valid = 1'b1;
    if (rx_q.size() < DEPTH) rx_q.push_back(d); else rx_ovf_m = 1'b1;
    @(posedge clk); #1 sw_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_q.delete(); rx_q.delete(); tx_ovf_m = 1'b0; rx_ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    repeat (2) @(negedge clk);
    pulse_reset();
    #1;
    total++; if (led !== '0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
    else $display("reset_led ok");
    total++; if ({seg_valid, seg_data} !== 33'd0) begin bad++; $display("FAIL reset_seg got=%b/%h exp=0/0", seg_valid, seg_data); end
    else $display("reset_seg ok");
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL reset_rx_stat got=%h exp=%h", got, rx_stat_m()); end
    else $display("reset_rx_stat ok %h", got);
    cpu_read(IO_RX_DATA, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL reset_rx_data got=%h exp=0", got); end
    else $display("reset_rx_data ok");
  endtask

  task automatic test_led();
    logic [31:0] got;
    cpu_write(IO_LED, 32'h0000ABCD);
    total++; if (led !== 16'hABCD) begin bad++; $display("FAIL led_out got=%h exp=abcd", led); end
    else $display("led_out ok %h", led);
    cpu_read(IO_LED, got);
    total++; if (got !== 32'h0000ABCD) begin bad++; $display("FAIL led_read got=%h exp=0000abcd", got); end
    else $display("led_read ok %h", got);
    cpu_write(IO_LED, 32'hFFFF1234);
    cpu_write(8'h0C, 32'h5555);
    cpu_read(IO_LED + 8'h3, got);
    total++; if (got !== 32'h00001234) begin bad++; $display("FAIL led_zext got=%h exp=00001234", got); end
    else $display("led_zext ok %h", got);
  endtask

  task automatic test_tx();
    logic [31:0] got;
    logic [31:0] exp;
    seg_ready = 1'b0;
    for (int i = 1; i <= 4; i++) cpu_write(IO_TX_DATA, 32'(i));
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL tx_full_stat got=%h exp=%h", got, tx_stat_m()); end
    else $display("tx_full_stat ok %h", got);
    cpu_write(IO_TX_DATA, 32'd5);
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL tx_ovf_stat got=%h exp=%h", got, tx_stat_m()); end
    else $display("tx_ovf_stat ok %h", got);
    @(negedge clk);
    seg_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 exp = (tx_q.size() != 0) ? tx_q.pop_front() : 32'hDEAD;
      total++; if ({seg_valid, seg_data} !== {1'b1, exp}) begin bad++; $display("FAIL tx_drain%0d got=%b/%h exp=1/%h", k, seg_valid, seg_data, exp); end
      else $display("tx_drain%0d ok %h", k, seg_data);
      @(negedge clk);
    end
    #1;
    total++; if (seg_valid !== 1'b0) begin bad++; $display("FAIL tx_empty got=%b exp=0", seg_valid); end
    else $display("tx_empty ok");
    seg_ready = 1'b0;
    cpu_write(IO_OVF_CLR, 32'h0);
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL tx_ovf_clr got=%h exp=%h", got, tx_stat_m()); end
    else $display("tx_ovf_clr ok %h", got);
  endtask

  // Full tx FIFO: push and pop in the same cycle must both succeed without overflow.
  task automatic test_back_to_back();
    logic [31:0] got;
    logic [31:0] exp;
    seg_ready = 1'b0;
    for (int i = 1; i <= 4; i++) cpu_write(IO_TX_DATA, 32'h100 + 32'(i));
    @(negedge clk);
    seg_ready = 1'b1; io_addr = IO_TX_DATA; io_dout = 32'h105; io_we = 1'b1;
    #1 exp = tx_q.pop_front();
    tx_q.push_back(32'h105);
    total++; if (seg_data !== exp) begin bad++; $display("FAIL b2b_head got=%h exp=%h", seg_data, exp); end
    else $display("b2b_head ok %h", seg_data);
    @(posedge clk); #1 io_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 exp = (tx_q.size() != 0) ? tx_q.pop_front() : 32'hDEAD;
      total++; if ({seg_valid, seg_data} !== {1'b1, exp}) begin bad++; $display("FAIL b2b_drain%0d got=%b/%h exp=1/%h", k, seg_valid, seg_data, exp); end
      else $display("b2b_drain%0d ok %h", k, seg_data);
    end
    @(negedge clk);
    seg_ready = 1'b0;
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL b2b_no_ovf got=%h exp=%h", got, tx_stat_m()); end
    else $display("b2b_no_ovf ok %h", got);
  endtask

  task automatic test_rx();
    logic [31:0] got;
    logic [31:0] exp;
    sw_push(32'h11);
    sw_push(32'h22);
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL rx_stat got=%h exp=%h", got, rx_stat_m()); end
    else $display("rx_stat ok %h", got);
    for (int k = 0; k < 3; k++) begin
      cpu_read(IO_RX_DATA, got);
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
      total++; if (got !== exp) begin bad++; $display("FAIL rx_pop%0d got=%h exp=%h", k, got, exp); end
      else $display("rx_pop%0d ok %h", k, got);
    end
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL rx_stat_empty got=%h exp=%h", got, rx_stat_m()); end
    else $display("rx_stat_empty ok %h", got);
  endtask

  task automatic test_rx_full();
    logic [31:0] got;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) sw_push(32'hA0 + 32'(i));
    @(negedge clk);
    sw_data = 32'hA4; sw_valid = 1'b1; io_addr = IO_RX_DATA; io_rd = 1'b1;
    #1 got = io_din;
    exp = rx_q.pop_front();
    rx_q.push_back(32'hA4);
    total++; if (got !== exp) begin bad++; $display("FAIL rx_full_simul got=%h exp=%h", got, exp); end
    else $display("rx_full_simul ok %h", got);
    @(posedge clk); #1 sw_valid = 1'b0; io_rd = 1'b0;
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL rx_full_no_ovf got=%h exp=%h", got, rx_stat_m()); end
    else $display("rx_full_no_ovf ok %h", got);
    sw_push(32'hEE);
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL rx_ovf got=%h exp=%h", got, rx_stat_m()); end
    else $display("rx_ovf ok %h", got);
    for (int k = 0; k < 4; k++) begin
      cpu_read(IO_RX_DATA, got);
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
      total++; if (got !== exp) begin bad++; $display("FAIL rx_full_drain%0d got=%h exp=%h", k, got, exp); end
      else $display("rx_full_drain%0d ok %h", k, got);
    end
    @(negedge clk);
    sw_data = 32'h77; sw_valid = 1'b1; io_addr = IO_RX_DATA; io_rd = 1'b1;
    #1 got = io_din;
    rx_q.push_back(32'h77);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL rx_empty_simul got=%h exp=0", got); end
    else $display("rx_empty_simul ok");
    @(posedge clk); #1 sw_valid = 1'b0; io_rd = 1'b0;
    cpu_read(IO_RX_DATA, got);
    exp = rx_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL rx_empty_simul_push got=%h exp=%h", got, exp); end
    else $display("rx_empty_simul_push ok %h", got);
    cpu_write(IO_OVF_CLR, 32'h1);
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL rx_ovf_clr got=%h exp=%h", got, rx_stat_m()); end
    else $display("rx_ovf_clr ok %h", got);
  endtask

  task automatic test_cycle();
    logic [31:0] c1;
    logic [31:0] c2;
    int          n;
    n = 37;
    @(negedge clk);
    io_addr = IO_CYCLE;
    #1 c1 = io_din;
    repeat (n) @(negedge clk);
    #1 c2 = io_din;
    total++; if (c2 - c1 !== 32'(n)) begin bad++; $display("FAIL cycle_delta got=%0d exp=%0d", c2 - c1, n); end
    else $display("cycle_delta ok %0d", c2 - c1);
    pulse_reset();
    io_addr = IO_CYCLE;
    #1 c1 = io_din;
    total++; if (c1 !== 32'h0) begin bad++; $display("FAIL cycle_reset got=%h exp=0", c1); end
    else $display("cycle_reset ok");
  endtask

  task automatic test_ovf_reset();
    logic [31:0] got;
    seg_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cpu_write(IO_TX_DATA, 32'h200 + 32'(i));
    for (int i = 1; i <= 5; i++) sw_push(32'h300 + 32'(i));
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL ovr_tx_set got=%h exp=%h", got, tx_stat_m()); end
    else $display("ovr_tx_set ok %h", got);
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL ovr_rx_set got=%h exp=%h", got, rx_stat_m()); end
    else $display("ovr_rx_set ok %h", got);
    cpu_write(IO_OVF_CLR, 32'h0);
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL ovr_tx_clr got=%h exp=%h", got, tx_stat_m()); end
    else $display("ovr_tx_clr ok %h", got);
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL ovr_rx_clr got=%h exp=%h", got, rx_stat_m()); end
    else $display("ovr_rx_clr ok %h", got);
    pulse_reset();
    #1;
    total++; if ({seg_valid, seg_data} !== 33'd0) begin bad++; $display("FAIL ovr_rst_seg got=%b/%h exp=0/0", seg_valid, seg_data); end
    else $display("ovr_rst_seg ok");
    cpu_read(IO_RX_STAT, got);
    total++; if (got !== rx_stat_m()) begin bad++; $display("FAIL ovr_rst_rx got=%h exp=%h", got, rx_stat_m()); end
    else $display("ovr_rst_rx ok %h", got);
    cpu_read(IO_TX_STAT, got);
    total++; if (got !== tx_stat_m()) begin bad++; $display("FAIL ovr_rst_tx got=%h exp=%h", got, tx_stat_m()); end
    else $display("ovr_rst_tx ok %h", got);
    cpu_read(IO_LED, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL ovr_rst_led got=%h exp=0", got); end
    else $display("ovr_rst_led ok");
  endtask

  initial begin
    test_reset();
    test_led();
    test_tx();
    test_back_to_back();
    test_rx();
    test_rx_full();
    test_cycle();
    test_ovf_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
